// File: rtl/paddle_draw.sv
// paddle_draw: rasterises one solid paddle rectangle, one pixel per clock, row-major,
// with an erase mode that repaints the same rectangle in black.
module paddle_draw #(
    parameter int         WIDTH  = 4,
    parameter int         HEIGHT = 16,
    parameter logic [2:0] COLOUR = 3'b111
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       erase,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    localparam logic [3:0] CX_LAST = 4'(WIDTH - 1);
    localparam logic [5:0] CY_LAST = 6'(HEIGHT - 1);

    state_t     state_q, state_d;
    logic [7:0] x0_q, x0_d;
    logic [6:0] y0_q, y0_d;
    logic       erase_q, erase_d;
    logic [3:0] cx_q, cx_d;
    logic [5:0] cy_q, cy_d;
    logic [7:0] x_out_q, x_out_d;
    logic [6:0] y_out_q, y_out_d;
    logic [2:0] colour_out_q, colour_out_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       on_screen;
    logic       last_col;
    logic       last_px;

    // Sums are one bit wider than the outputs so off-screen pixels are clipped, not wrapped.
    always_comb begin
        x_sum        = {1'b0, x0_q} + 9'(cx_q);
        y_sum        = {1'b0, y0_q} + 8'(cy_q);
        on_screen    = (x_sum <= 9'd159) && (y_sum <= 8'd119);
        last_col     = cx_q == CX_LAST;
        last_px      = last_col && (cy_q == CY_LAST);
        state_d      = state_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        erase_d      = erase_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        colour_out_d = colour_out_q;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        if (state_q == IDLE && start) begin
            state_d = DRAW;
            x0_d    = x_in;
            y0_d    = y_in;
            erase_d = erase;
            cx_d    = '0;
            cy_d    = '0;
        end else if (state_q == DRAW) begin
            x_out_d      = x_sum[7:0];
            y_out_d      = y_sum[6:0];
            colour_out_d = erase_q ? 3'b000 : COLOUR;
            plot_d       = on_screen;
            busy_d       = 1'b1;
            cx_d         = last_col ? 4'd0 : cx_q + 4'd1;
            cy_d         = last_col ? cy_q + 6'd1 : cy_q;
            state_d      = last_px ? FINISH : DRAW;
        end else if (state_q == FINISH) begin
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            erase_q      <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            colour_out_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            erase_q      <= erase_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            colour_out_q <= colour_out_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign colour_out = colour_out_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_paddle_draw.sv
// tb_paddle_draw: per-cycle reference model for a default paddle and a 1x1 paddle,
// plus directed scenarios with hand-computed pixel/timing expectations.
module tb_paddle_draw;
    localparam int W = 4;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st[2];
    logic       er[2];
    logic [7:0] xi[2];
    logic [6:0] yi[2];
    logic [7:0] xo[2];
    logic [6:0] yo[2];
    logic [2:0] co[2];
    logic       pl[2];
    logic       bz[2];
    logic       dn[2];

    always #5 clk = ~clk;

    paddle_draw u0 (
        .CLOCK_50(clk), .reset(rst), .start(st[0]), .erase(er[0]), .x_in(xi[0]), .y_in(yi[0]),
        .x_out(xo[0]), .y_out(yo[0]), .colour_out(co[0]), .plot(pl[0]), .busy(bz[0]), .done(dn[0])
    );

    paddle_draw #(.WIDTH(1), .HEIGHT(1)) u1 (
        .CLOCK_50(clk), .reset(rst), .start(st[1]), .erase(er[1]), .x_in(xi[1]), .y_in(yi[1]),
        .x_out(xo[1]), .y_out(yo[1]), .colour_out(co[1]), .plot(pl[1]), .busy(bz[1]), .done(dn[1])
    );

    int tests = 0;
    int fails = 0;
    int ecnt  = 0;

    function automatic int npx(int d);
        return d != 0 ? 1 : W * H;
    endfunction

    function automatic int wid(int d);
        return d != 0 ? 1 : W;
    endfunction

    task automatic chk(string nm, int d, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (edge %0d)", nm, d, act, exp, ecnt);
        end
    endtask

    // Reference model: n counts edges since the accepted start; pixel k appears after edge k+1.
    bit act[2];
    int n[2], mx[2], my[2], me[2];
    bit e_pl[2], e_bz[2], e_dn[2], e_z[2];
    int e_x[2], e_y[2], e_c[2];

    always @(posedge clk) begin
        ecnt++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                act[d] = 0;
                n[d] = 0;
                e_pl[d] = 0;
                e_bz[d] = 0;
                e_dn[d] = 0;
                e_z[d] = 1;
            end else begin
                e_z[d] = 0;
                if ((!act[d] || n[d] >= npx(d) + 1) && st[d]) begin
                    act[d] = 1;
                    n[d] = 0;
                    mx[d] = int'(xi[d]);
                    my[d] = int'(yi[d]);
                    me[d] = int'(er[d]);
                end else if (act[d]) begin
                    n[d]++;
                end
                e_dn[d] = act[d] && n[d] == npx(d) + 1;
                e_bz[d] = act[d] && n[d] >= 1 && n[d] <= npx(d);
                e_x[d]  = mx[d] + (n[d] - 1) % wid(d);
                e_y[d]  = my[d] + (n[d] - 1) / wid(d);
                e_c[d]  = me[d] != 0 ? 0 : 7;
                e_pl[d] = e_bz[d] && e_x[d] <= 159 && e_y[d] <= 119;
            end
        end
    end

    int s_edge[2], plots[2], dones[2], done_at[2], zc[2];
    int fx[2], fy[2], x5[2], y5[2], lx[2], ly[2], minx[2], maxx[2], miny[2], maxy[2];

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("plot", d, int'(pl[d]), int'(e_pl[d]));
            chk("busy", d, int'(bz[d]), int'(e_bz[d]));
            chk("done", d, int'(dn[d]), int'(e_dn[d]));
            if (e_pl[d] || e_z[d]) begin
                chk("x_out", d, int'(xo[d]), e_z[d] ? 0 : e_x[d]);
                chk("y_out", d, int'(yo[d]), e_z[d] ? 0 : e_y[d]);
                chk("colour", d, int'(co[d]), e_z[d] ? 0 : e_c[d]);
            end
            if (pl[d]) begin
                if (plots[d] == 0) begin
                    fx[d] = int'(xo[d]);
                    fy[d] = int'(yo[d]);
                end
                if (plots[d] == 4) begin
                    x5[d] = int'(xo[d]);
                    y5[d] = int'(yo[d]);
                end
                lx[d] = int'(xo[d]);
                ly[d] = int'(yo[d]);
                if (int'(xo[d]) < minx[d]) minx[d] = int'(xo[d]);
                if (int'(xo[d]) > maxx[d]) maxx[d] = int'(xo[d]);
                if (int'(yo[d]) < miny[d]) miny[d] = int'(yo[d]);
                if (int'(yo[d]) > maxy[d]) maxy[d] = int'(yo[d]);
                if (co[d] == 3'b000) zc[d]++;
                plots[d]++;
            end
            if (dn[d]) begin
                dones[d]++;
                done_at[d] = ecnt - s_edge[d];
            end
        end
    end

    task automatic clear_stats(int d);
        plots[d] = 0;
        dones[d] = 0;
        done_at[d] = -1;
        zc[d] = 0;
        fx[d] = -1;
        fy[d] = -1;
        x5[d] = -1;
        y5[d] = -1;
        lx[d] = -1;
        ly[d] = -1;
        minx[d] = 999;
        maxx[d] = -1;
        miny[d] = 999;
        maxy[d] = -1;
    endtask

    // Called just after a negedge; start is sampled on the following posedge.
    task automatic go(int d, int x, int y, bit e);
        clear_stats(d);
        xi[d] = 8'(x);
        yi[d] = 7'(y);
        er[d] = e;
        st[d] = 1'b1;
        s_edge[d] = ecnt + 1;
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic wait_done(int d);
        int c = 0;
        while (dones[d] == 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (dones[d] == 0) chk("done_timeout", d, dones[d], 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            st[d] = 0;
            er[d] = 0;
            xi[d] = 0;
            yi[d] = 0;
            clear_stats(d);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        go(0, 0, 54, 0);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("t1_plots", 0, plots[0], 64);
        chk("t1_first_x", 0, fx[0], 0);
        chk("t1_first_y", 0, fy[0], 54);
        chk("t1_fifth_x", 0, x5[0], 0);
        chk("t1_fifth_y", 0, y5[0], 55);
        chk("t1_last_x", 0, lx[0], 3);
        chk("t1_last_y", 0, ly[0], 69);
        chk("t1_done_edge", 0, done_at[0], 65);
        chk("t1_done_count", 0, dones[0], 1);
        chk("t1_black_px", 0, zc[0], 0);

        go(0, 118, 54, 1);
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("t2_plots", 0, plots[0], 64);
        chk("t2_min_x", 0, minx[0], 118);
        chk("t2_max_x", 0, maxx[0], 121);
        chk("t2_min_y", 0, miny[0], 54);
        chk("t2_max_y", 0, maxy[0], 69);
        chk("t2_black_px", 0, zc[0], 64);

        go(0, 158, 110, 0);
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("clip_plots", 0, plots[0], 20);
        chk("clip_min_x", 0, minx[0], 158);
        chk("clip_max_x", 0, maxx[0], 159);
        chk("clip_min_y", 0, miny[0], 110);
        chk("clip_max_y", 0, maxy[0], 119);
        chk("clip_done_edge", 0, done_at[0], 65);

        go(0, 0, 54, 0);
        repeat (9) @(negedge clk);
        xi[0] = 8'd50;
        yi[0] = 7'd50;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0);
        chk("restart_first_y", 0, fy[0], 54);
        chk("restart_last_x", 0, lx[0], 3);
        chk("restart_last_y", 0, ly[0], 69);
        chk("restart_max_x", 0, maxx[0], 3);
        chk("restart_plots", 0, plots[0], 64);
        chk("restart_done_edge", 0, done_at[0], 65);
        go(0, 10, 20, 0);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("fresh_plots", 0, plots[0], 64);
        chk("fresh_first_x", 0, fx[0], 10);
        chk("fresh_last_y", 0, ly[0], 35);
        chk("fresh_done_count", 0, dones[0], 1);
        chk("fresh_done_edge", 0, done_at[0], 65);

        go(0, 20, 30, 0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("rst_done_count", 0, dones[0], 0);
        chk("rst_plots", 0, plots[0], 19);
        go(0, 20, 30, 0);
        wait_done(0);
        repeat (2) @(negedge clk);
        chk("post_rst_plots", 0, plots[0], 64);
        chk("post_rst_done_edge", 0, done_at[0], 65);

        go(1, 159, 119, 0);
        wait_done(1);
        repeat (2) @(negedge clk);
        chk("one_plots", 1, plots[1], 1);
        chk("one_x", 1, fx[1], 159);
        chk("one_y", 1, fy[1], 119);
        chk("one_done_edge", 1, done_at[1], 2);

        repeat (3000) begin
            @(negedge clk);
            rst = $urandom_range(0, 299) == 0;
            for (int d = 0; d < 2; d++) begin
                st[d] = $urandom_range(0, 11) == 0;
                er[d] = 1'($urandom);
                xi[d] = 8'($urandom);
                yi[d] = 7'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        st[0] = 1'b0;
        st[1] = 1'b0;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/paddle_draw.md
# paddle_draw

Rasterises one solid paddle rectangle into the VGA frame buffer. It sits directly downstream of the paddle start-position logic, which produces an (x, y) paddle origin. On a `start` pulse it latches that origin and emits one pixel per clock (`x_out`, `y_out`, `colour_out`, `plot`) to the VGA adapter. It then pulses `done`. An erase mode redraws the same rectangle in black, so the game FSM can move a paddle with erase-then-draw.

## Interface
- `WIDTH`, default 4: paddle width in pixels (1–16).
- `HEIGHT`, default 16: paddle height in pixels (1–64).
- `COLOUR`, default 3'b111: draw colour; erase always uses 3'b000.
- `CLOCK_50`  in  1: the single clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to draw; honoured only in IDLE.
- `erase`  in  1: sampled with `start`; 1 selects black.
- `x_in`  in  8: paddle origin column (top-left), sampled with `start`.
- `y_in`  in  7: paddle origin row (top-left), sampled with `start`.
- `x_out`  out  8: pixel column to the VGA adapter.
- `y_out`  out  7: pixel row to the VGA adapter.
- `colour_out`  out  3: pixel colour.
- `plot`  out  1: write enable to the VGA adapter.
- `busy`  out  1: high from the cycle after an accepted start through the last pixel cycle.
- `done`  out  1: one-cycle completion pulse.

## Operation
- All outputs are registered. Reset value of every output is 0: `x_out`, `y_out`, `colour_out`, `plot`, `busy`, `done`.
- The FSM has three states: IDLE, DRAW, FINISH.
  - IDLE: when `start`=1, latch `x_in`, `y_in` and `erase`, clear counters `cx` and `cy`, go to DRAW. Otherwise stay in IDLE.
  - DRAW: each cycle emit the pixel at (x0+cx, y0+cy).
    - `cx` increments every cycle. When `cx` = WIDTH-1 it wraps to 0 and `cy` increments.
    - At `cx` = WIDTH-1 and `cy` = HEIGHT-1, go to FINISH.
  - FINISH: `done`=1 for one cycle, `plot`=0, return to IDLE.
- Scan order is row-major: columns are the inner loop, rows the outer loop.
- Pixel address arithmetic:
  - Column sum x0+cx is computed at 9 bits; row sum y0+cy is computed at 8 bits. No wrap-around is allowed.
  - A pixel is on-screen iff its column sum is ≤ 159 and its row sum is ≤ 119.
  - On-screen pixel: `plot`=1, `x_out`/`y_out` = sums truncated to 8/7 bits.
  - Off-screen pixel: `plot`=0. The scan still spends the cycle, so latency is independent of position.
- `colour_out` = COLOUR, or 3'b000 if the latched `erase`=1. The colour is constant for the whole rectangle.
- `start` while in DRAW or FINISH is ignored. It is not queued, and latched values are unchanged.
- `x_in`, `y_in` and `erase` changing during DRAW have no effect.
- `reset` asserted in any state forces IDLE and zeroes all outputs and counters on the next edge. The partially drawn rectangle is not completed.
- Counters: `cx` is 4 bits, `cy` is 6 bits.

## Timing
- `start` is sampled at edge 0.
- The first pixel (cx=0, cy=0) is presented after edge 1, with `busy`=1.
- Pixel k (0-based) is presented after edge k+1, for k = 0 … WIDTH·HEIGHT−1.
- `done` is high after edge WIDTH·HEIGHT+1, and `busy` is 0 in that cycle.
- The earliest accepted next `start` is at edge WIDTH·HEIGHT+2, which is the first IDLE cycle. This gives back-to-back draws with a one-cycle gap.
- With defaults: 64 pixel cycles, `done` after edge 65.
- `plot` is never high in IDLE or FINISH.

## Test plan
- Defaults, `start` with (x_in, y_in) = (0, 54), erase=0:
  - expect 64 `plot` pulses with colour 3'b111;
  - first pixel (0, 54), 5th pixel (0, 55), last pixel (3, 69);
  - `done` a single cycle after edge 65.
- `start` with (118, 54), erase=1: expect 64 pixels spanning x 118–121 and y 54–69, all with colour 3'b000.
- Clipping: `start` with (158, 110):
  - expect exactly 20 `plot` pulses, x ∈ {158, 159}, y 110–119;
  - no pixel with x ≥ 160 or y ≥ 120 is plotted;
  - `done` still after edge 65.
- `start` re-asserted at edge 10 with (50, 50) during a draw from (0, 54):
  - the draw continues at the original origin;
  - exactly one `done`;
  - a fresh `start` at edge 66 is accepted.
- `reset` at edge 20 mid-draw:
  - next cycle all outputs are 0 and the FSM is in IDLE;
  - no `done` pulse;
  - a subsequent `start` produces a full 64-pixel draw.
- Parameter override WIDTH=1, HEIGHT=1, `start` with (159, 119): exactly one pixel at (159, 119), then `done` after edge 2.
